fusion_pair_buffer: RTL

// - Macro-op fusion stage between the instruction realigner / instr queue and the ID stage.
// - Holds one 32-bit uncompressed instruction that can start a fused pair (a fusion "head").
// - When the next contiguous instruction forms a supported pair, emits both as one fused

---
 rtl/fusion_pair_buffer.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/fusion_pair_buffer.sv
// Macro-op fusion buffer between the instruction queue and the decode stage.
// It holds one instruction that may start a fused pair. When the next contiguous
// instruction completes a supported pair, both leave together as one macro-op.
// Otherwise instructions leave one at a time, in program order.

// Minimal core-configuration description. Only the fields this block reads are kept.
package config_pkg;
  typedef struct packed {
    int unsigned VLEN;
    logic        IS_XLEN64;
  } cva6_cfg_t;
endpackage

package cva6_config_pkg;
  localparam config_pkg::cva6_cfg_t cva6_cfg = '{VLEN: 64, IS_XLEN64: 1'b1};
endpackage

module fusion_pair_buffer #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg       = cva6_config_pkg::cva6_cfg,
  parameter bit                    FuseLuiAddi   = 1'b1,
  parameter bit                    FuseAuipcAddi = 1'b1,
  parameter bit                    FuseZextW     = 1'b1,
  parameter int unsigned           FuseTimeout   = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [31:0]             instr_i,
  input  logic [CVA6Cfg.VLEN-1:0] pc_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [31:0]             instr_o,
  output logic [31:0]             instr2_o,
  output logic [CVA6Cfg.VLEN-1:0] pc_o,
  output logic                    fused_o,
  output logic [1:0]              fuse_kind_o
);

  localparam int unsigned VLEN = CVA6Cfg.VLEN;
  localparam int unsigned CntW = $clog2(FuseTimeout) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(FuseTimeout - 1);
  // A 32-bit core has no use for zero-extending a word, so this kind is disabled there.
  localparam bit ZextEn = FuseZextW && CVA6Cfg.IS_XLEN64;

  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [1:0] KindNone  = 2'd0;
  localparam logic [1:0] KindLui   = 2'd1;
  localparam logic [1:0] KindAuipc = 2'd2;
  localparam logic [1:0] KindZext  = 2'd3;

  typedef enum logic [0:0] {EMPTY, HOLD} state_e;

  state_e            state_q, state_d;
  logic [31:0]       slot_instr_q, slot_instr_d;
  logic [VLEN-1:0]   slot_pc_q, slot_pc_d;
  logic              slot_head_q, slot_head_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [31:0]       out_instr2_q, out_instr2_d;
  logic [VLEN-1:0]   out_pc_q, out_pc_d;
  logic              out_fused_q, out_fused_d;
  logic [1:0]        out_kind_q, out_kind_d;

  logic              out_free;
  logic              in_head;
  logic [1:0]        slot_kind;
  logic              kind_en;
  logic              second_ok;
  logic              match;

  // Classifies an instruction as a pair head and reports which pair it could start.
  function automatic logic [1:0] head_kind(input logic [31:0] ins);
    logic [1:0] k;
    k = KindNone;
    if (ins[6:0] == OpcLui && ins[11:7] != 5'd0) begin
      k = KindLui;
    end else if (ins[6:0] == OpcAuipc && ins[11:7] != 5'd0) begin
      k = KindAuipc;
    end else if (ZextEn && ins[6:0] == OpcOpImm && ins[14:12] == 3'b001 &&
                 ins[31:26] == 6'd0 && ins[25:20] == 6'd32) begin
      k = KindZext;
    end
    return k;
  endfunction

  assign out_free = !out_valid_q || ready_i;
  assign ready_o  = out_free && !flush_i;
  assign in_head  = (head_kind(instr_i) != KindNone);

  // Decide whether the incoming instruction completes a pair with the held head.
  always_comb begin
    slot_kind = head_kind(slot_instr_q);
    kind_en   = 1'b0;
    second_ok = 1'b0;
    case (slot_kind)
      KindLui: begin
        kind_en   = FuseLuiAddi;
        second_ok = (instr_i[14:12] == 3'b000);
      end
      KindAuipc: begin
        kind_en   = FuseAuipcAddi;
        second_ok = (instr_i[14:12] == 3'b000);
      end
      KindZext: begin
        kind_en   = ZextEn;
        second_ok = (instr_i[14:12] == 3'b101) && (instr_i[31:26] == 6'd0) &&
                    (instr_i[25:20] == 6'd32);
      end
      default: begin
        kind_en   = 1'b0;
        second_ok = 1'b0;
      end
    endcase
    match = slot_head_q && kind_en && second_ok &&
            (pc_i == slot_pc_q + VLEN'(4)) &&
            (instr_i[6:0] == OpcOpImm) &&
            (instr_i[19:15] == slot_instr_q[11:7]) &&
            (instr_i[11:7] == slot_instr_q[11:7]);
  end

  // Next-state logic for the slot, the wait counter and the output register.
  always_comb begin
    state_d      = state_q;
    slot_instr_d = slot_instr_q;
    slot_pc_d    = slot_pc_q;
    slot_head_d  = slot_head_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_instr2_d = out_instr2_q;
    out_pc_d     = out_pc_q;
    out_fused_d  = out_fused_q;
    out_kind_d   = out_kind_q;

    if (out_free) begin
      out_valid_d = 1'b0;
    end

    if (flush_i) begin
      state_d     = EMPTY;
      slot_head_d = 1'b0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (valid_i && out_free) begin
            if (in_head) begin
              slot_instr_d = instr_i;
              slot_pc_d    = pc_i;
              slot_head_d  = 1'b1;
              cnt_d        = '0;
              state_d      = HOLD;
            end else begin
              out_valid_d  = 1'b1;
              out_instr_d  = instr_i;
              out_instr2_d = '0;
              out_pc_d     = pc_i;
              out_fused_d  = 1'b0;
              out_kind_d   = KindNone;
            end
          end
        end
        HOLD: begin
          if (out_free) begin
            if (valid_i && match) begin
              out_valid_d  = 1'b1;
              out_instr_d  = slot_instr_q;
              out_instr2_d = instr_i;
              out_pc_d     = slot_pc_q;
              out_fused_d  = 1'b1;
              out_kind_d   = slot_kind;
              slot_head_d  = 1'b0;
              cnt_d        = '0;
              state_d      = EMPTY;
            end else if (valid_i) begin
              out_valid_d  = 1'b1;
              out_instr_d  = slot_instr_q;
              out_instr2_d = '0;
              out_pc_d     = slot_pc_q;
              out_fused_d  = 1'b0;
              out_kind_d   = KindNone;
              slot_instr_d = instr_i;
              slot_pc_d    = pc_i;
              slot_head_d  = in_head;
              cnt_d        = '0;
            end else if (!slot_head_q || cnt_q == CntMax) begin
              out_valid_d  = 1'b1;
              out_instr_d  = slot_instr_q;
              out_instr2_d = '0;
              out_pc_d     = slot_pc_q;
              out_fused_d  = 1'b0;
              out_kind_d   = KindNone;
              slot_head_d  = 1'b0;
              cnt_d        = '0;
              state_d      = EMPTY;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // State registers; reset discards anything held.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= EMPTY;
      slot_instr_q <= '0;
      slot_pc_q    <= '0;
      slot_head_q  <= 1'b0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_instr2_q <= '0;
      out_pc_q     <= '0;
      out_fused_q  <= 1'b0;
      out_kind_q   <= '0;
    end else begin
      state_q      <= state_d;
      slot_instr_q <= slot_instr_d;
      slot_pc_q    <= slot_pc_d;
      slot_head_q  <= slot_head_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_instr2_q <= out_instr2_d;
      out_pc_q     <= out_pc_d;
      out_fused_q  <= out_fused_d;
      out_kind_q   <= out_kind_d;
    end
  end

  assign valid_o     = out_valid_q;
  assign instr_o     = out_instr_q;
  assign instr2_o    = out_instr2_q;
  assign pc_o        = out_pc_q;
  assign fused_o     = out_fused_q;
  assign fuse_kind_o = out_kind_q;

endmodule
